// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, req/ack fetch FSM, skid buffer and IF_ID register.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage #(
  parameter int unsigned     SIZE     = 32,
  parameter logic [SIZE-1:0] RESET_PC = '0,
  parameter logic [SIZE-1:0] NOP      = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [SIZE-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [SIZE-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [SIZE-1:0]   imem_rdata,
  output logic [2*SIZE-1:0] IF_ID,
  output logic              if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [SIZE-1:0]   fetch_count,
  output logic [SIZE-1:0]   stall_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DISCARD} state_e;

  localparam logic [SIZE-1:0]   PC_STEP  = SIZE'(4);
  localparam logic [SIZE-1:0]   LOW_MASK = SIZE'(3);
  localparam logic [2*SIZE-1:0] IF_ID_FLUSH = {{SIZE{1'b0}}, NOP};

  state_e            state_q, state_d;
  logic [SIZE-1:0]   pc_q, pc_d;
  logic [SIZE-1:0]   addr_q, addr_d;
  logic              req_q, req_d;
  logic [2*SIZE-1:0] if_id_q, if_id_d;
  logic              valid_q, valid_d;
  logic [2*SIZE-1:0] skid_q, skid_d;
  logic              load_valid;
  logic [SIZE-1:0]   pc_plus4;
  logic [SIZE-1:0]   redirect_aligned;

  assign pc_plus4         = pc_q + PC_STEP;
  assign redirect_aligned = redirect_pc & ~LOW_MASK;

  // State register together with all registered outputs and datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      if_id_q <= IF_ID_FLUSH;
      valid_q <= 1'b0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      if_id_q <= if_id_d;
      valid_q <= valid_d;
      skid_q  <= skid_d;
    end
  end

  // Next state: a redirect never waits, except that an un-acked request must drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = S_REQ;
      S_REQ: begin
        if (redirect)
          state_d = imem_ack ? S_REQ : S_DISCARD;
        else if (imem_ack && stall)
          state_d = S_HOLD;
      end
      S_HOLD:    if (redirect || !stall) state_d = S_REQ;
      S_DISCARD: if (imem_ack) state_d = S_REQ;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    if_id_d    = if_id_q;
    valid_d    = valid_q;
    skid_d     = skid_q;
    load_valid = 1'b0;
    if (redirect) begin
      pc_d    = redirect_aligned;
      if_id_d = IF_ID_FLUSH;
      valid_d = 1'b0;
      skid_d  = '0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_ack) begin
            pc_d = pc_plus4;
            if (stall) begin
              skid_d = {pc_plus4, imem_rdata};
            end else begin
              if_id_d    = {pc_plus4, imem_rdata};
              valid_d    = 1'b1;
              load_valid = 1'b1;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if_id_d    = skid_q;
            valid_d    = 1'b1;
            load_valid = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // DISCARD keeps the stale address on the bus until its ack drains.
    req_d  = (state_d == S_REQ) || (state_d == S_DISCARD);
    addr_d = (state_d == S_DISCARD) ? addr_q : pc_d;
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign IF_ID       = if_id_q;
  assign if_id_valid = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [SIZE-1:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (load_valid) fetch_cnt_q <= fetch_cnt_q + SIZE'(1);
      if (stall)      stall_cnt_q <= stall_cnt_q + SIZE'(1);
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  logic unused_load;
  assign unused_load = load_valid;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage: each row is one clock of stimulus
// followed by the registered outputs expected after that edge.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [63:0] IF_ID;
  logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  if_stage #(.SIZE(32), .RESET_PC(32'h0), .NOP(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .IF_ID       (IF_ID),
    .if_id_valid (if_id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, redir, ack;
    logic [31:0] rpc, rdata;
    logic        req;
    logic [31:0] addr;
    logic [63:0] if_id;
    logic        valid;
  } vec_t;

  vec_t vq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic add(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                     input logic a, input logic [31:0] data, input logic req,
                     input logic [31:0] addr, input logic [63:0] ifid, input logic valid);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = rd; v.rpc = rpc; v.ack = a; v.rdata = data;
    v.req = req; v.addr = addr; v.if_id = ifid; v.valid = valid;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic req, input logic [31:0] addr,
                               input logic [63:0] ifid, input logic valid);
    check({tag, ".imem_req"}, 64'(imem_req), 64'(req));
    check({tag, ".imem_addr"}, 64'(imem_addr), 64'(addr));
    check({tag, ".IF_ID"}, IF_ID, ifid);
    check({tag, ".valid"}, 64'(if_id_valid), 64'(valid));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst stall redir rpc          ack rdata          req addr          IF_ID                          valid
    add(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0,        64'h0,                         0); // IDLE->REQ
    add(0, 0, 0, 32'h0,          1, 32'h20080001,   1, 32'h4,        {32'h4, 32'h20080001},         1);
    add(0, 0, 0, 32'h0,          1, 32'h20090002,   1, 32'h8,        {32'h8, 32'h20090002},         1);
    add(0, 0, 0, 32'h0,          1, 32'h200A0003,   1, 32'hC,        {32'hC, 32'h200A0003},         1);
    add(1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,        64'h0,                         0); // reset
    add(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0,        64'h0,                         0);
    add(0, 0, 0, 32'h0,          1, 32'h11111111,   1, 32'h4,        {32'h4, 32'h11111111},         1);
    add(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h4,        {32'h4, 32'h11111111},         0); // wait 1
    add(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h4,        {32'h4, 32'h11111111},         0);
    add(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h4,        {32'h4, 32'h11111111},         0);
    add(0, 0, 0, 32'h0,          1, 32'h22222222,   1, 32'h8,        {32'h8, 32'h22222222},         1);
    add(0, 1, 0, 32'h0,          1, 32'h01095020,   0, 32'hC,        {32'h8, 32'h22222222},         1); // ->HOLD
    add(0, 1, 0, 32'h0,          0, 32'h0,          0, 32'hC,        {32'h8, 32'h22222222},         1);
    add(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'hC,        {32'hC, 32'h01095020},         1); // skid out
    add(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'hC,        {32'hC, 32'h01095020},         0);
    add(0, 0, 1, 32'h103,        0, 32'h0,          1, 32'hC,        64'h0,                         0); // ->DISCARD
    add(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'hC,        64'h0,                         0);
    add(0, 0, 0, 32'h0,          1, 32'hDEADBEEF,   1, 32'h100,      64'h0,                         0); // dropped
    add(0, 0, 0, 32'h0,          1, 32'h33333333,   1, 32'h104,      {32'h104, 32'h33333333},       1);
    add(0, 0, 1, 32'h200,        1, 32'h44444444,   1, 32'h200,      64'h0,                         0); // redir+ack
    add(0, 0, 0, 32'h0,          1, 32'h55555555,   1, 32'h204,      {32'h204, 32'h55555555},       1);
    add(0, 1, 0, 32'h0,          1, 32'h66666666,   0, 32'h208,      {32'h204, 32'h55555555},       1);
    add(0, 1, 1, 32'h300,        0, 32'h0,          1, 32'h300,      64'h0,                         0); // redir in HOLD
    add(0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h300,      64'h0,                         0);
    add(0, 0, 0, 32'h0,          1, 32'h77777777,   1, 32'h304,      {32'h304, 32'h77777777},       1);
    add(0, 0, 1, 32'h400,        0, 32'h0,          1, 32'h304,      64'h0,                         0);
    add(0, 0, 1, 32'h500,        0, 32'h0,          1, 32'h304,      64'h0,                         0); // 2nd redir
    add(0, 0, 0, 32'h0,          1, 32'h88888888,   1, 32'h500,      64'h0,                         0);
    add(0, 0, 0, 32'h0,          1, 32'h99999999,   1, 32'h504,      {32'h504, 32'h99999999},       1);
    add(0, 0, 1, 32'hFFFFFFFF,   1, 32'h12345678,   1, 32'hFFFFFFFC, 64'h0,                         0);
    add(0, 0, 0, 32'h0,          1, 32'hAAAAAAAA,   1, 32'h0,        {32'h0, 32'hAAAAAAAA},         1); // wrap

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 32'h0, 64'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
    check("reset.fetch_count", 64'(fetch_count), 64'h0);
    check("reset.stall_count", 64'(stall_count), 64'h0);
`endif

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; stall = vq[i].stall; redirect = vq[i].redir;
      redirect_pc = vq[i].rpc; imem_ack = vq[i].ack; imem_rdata = vq[i].rdata;
      tick();
      $display("row %0d: req=%0b addr=%h IF_ID=%h valid=%0b", i, imem_req, imem_addr, IF_ID, if_id_valid);
      check_outputs($sformatf("row%0d", i), vq[i].req, vq[i].addr, vq[i].if_id, vq[i].valid);
`ifdef IF_PERF_CNT_EN
      if (i == 13) begin
        check("perf.fetch_count", 64'(fetch_count), 64'd3);
        check("perf.stall_count", 64'(stall_count), 64'd2);
      end
`endif
    end

    // Asynchronous reset while parked in HOLD.
    rst = 0; stall = 1; redirect = 0; imem_ack = 1; imem_rdata = 32'hBBBBBBBB;
    tick();
    $display("hold: req=%0b addr=%h IF_ID=%h valid=%0b", imem_req, imem_addr, IF_ID, if_id_valid);
    check_outputs("hold", 1'b0, 32'h4, {32'h0, 32'hAAAAAAAA}, 1'b1);
    imem_ack = 0;
    #3 rst = 1;
    #1;
    $display("async_rst: req=%0b addr=%h IF_ID=%h valid=%0b", imem_req, imem_addr, IF_ID, if_id_valid);
    check_outputs("async_rst", 1'b0, 32'h0, 64'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
    check("async_rst.fetch_count", 64'(fetch_count), 64'h0);
`endif
    tick();
    rst = 0; stall = 0;
    #1;
    $display("idle: req=%0b addr=%h", imem_req, imem_addr);
    check_outputs("idle", 1'b0, 32'h0, 64'h0, 1'b0);
    tick();
    $display("req_after_rst: req=%0b addr=%h", imem_req, imem_addr);
    check_outputs("req_after_rst", 1'b1, 32'h0, 64'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
